// File: rtl/control_sequencer.sv
// Control sequencer for the 8-bit, 5-stage core: decodes the instruction register into the
// current datapath state, with memory wait-states, multi-beat multiply write-back and fault halt.
module control_sequencer #(
  parameter int INSTR_WIDTH  = 16,
  parameter int RESULT_BEATS = 2,
  parameter int WAIT_LIMIT   = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   mem_ready,
  input  logic                   resume,
  output logic [4:0]             state,
  output logic                   halted,
  output logic                   fault,
  output logic                   instr_done,
  output logic [1:0]             beat
);

  localparam logic [4:0] OP_NOP      = 5'b00000;
  localparam logic [4:0] OP_MULTIPLY = 5'b00101;
  localparam logic [4:0] OP_LOAD     = 5'b10000;
  localparam logic [4:0] OP_STORE    = 5'b10001;
  localparam logic [4:0] OP_MOVE     = 5'b10010;
  localparam logic [4:0] OP_JUMP     = 5'b10011;

  localparam logic [1:0] SOURCE_REGISTER  = 2'b00;
  localparam logic [1:0] SOURCE_IMMEDIATE = 2'b01;
  localparam logic [1:0] SOURCE_MEMORY    = 2'b10;

  typedef enum logic [4:0] {
    S_RESET           = 5'd0,
    S_FETCH_1         = 5'd1,
    S_FETCH_2         = 5'd2,
    S_FETCH_IMMEDIATE = 5'd3,
    S_FETCH_ADDRESS_1 = 5'd4,
    S_FETCH_ADDRESS_2 = 5'd5,
    S_FETCH_ADDRESS_3 = 5'd6,
    S_FETCH_ADDRESS_4 = 5'd7,
    S_LOAD_JUMP_1     = 5'd8,
    S_LOAD_JUMP_2     = 5'd9,
    S_EXECUTE_JUMP    = 5'd10,
    S_COPY_REGISTER_1 = 5'd11,
    S_COPY_REGISTER_2 = 5'd12,
    S_FETCH_MEMORY    = 5'd13,
    S_STORE_MEMORY    = 5'd14,
    S_TEMP_FETCH      = 5'd15,
    S_TEMP_STORE      = 5'd16,
    S_ALU_OPERATION   = 5'd17,
    S_STORE_RESULT_1  = 5'd18,
    S_STORE_RESULT_2  = 5'd19,
    S_HALT            = 5'd20
  } state_t;

  // Counter saturates at the limit, so with the timeout disabled it simply sits at zero.
  localparam int                WAIT_W    = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(WAIT_LIMIT);
  localparam logic [1:0]        LAST_BEAT = 2'(RESULT_BEATS - 1);

  state_t            state_q, state_d;
  logic              fault_q, fault_d;
  logic              done_q, done_d;
  logic [1:0]        beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [4:0] op;
  logic [1:0] src;
  logic       isAlu;
  logic       isMem;
  logic       stall;
  logic       setFault;

  assign op  = instruction[INSTR_WIDTH-1 -: 5];
  assign src = instruction[INSTR_WIDTH-6 -: 2];

  assign isAlu = (op[4] == 1'b0) && (op != 5'b01101) && (op != 5'b01110) && (op != OP_NOP);

  always_comb begin
    isMem = 1'b0;
    case (state_q)
      S_FETCH_2, S_FETCH_IMMEDIATE, S_FETCH_ADDRESS_2, S_FETCH_ADDRESS_4, S_LOAD_JUMP_2,
      S_FETCH_MEMORY, S_STORE_MEMORY, S_TEMP_FETCH, S_TEMP_STORE: isMem = 1'b1;
      default: isMem = 1'b0;
    endcase
  end

  assign stall = isMem && !mem_ready;

  always_comb begin
    state_d  = state_q;
    setFault = 1'b0;
    if (stall) begin
      if ((WAIT_LIMIT > 0) && (wait_q == WAIT_MAX)) begin
        state_d  = S_HALT;
        setFault = 1'b1;
      end
    end else begin
      case (state_q)
        S_RESET:   state_d = S_FETCH_1;
        S_FETCH_1: state_d = S_FETCH_2;
        S_FETCH_2: begin
          if (op == OP_NOP) begin
            state_d = S_FETCH_1;
          end else if (op == OP_JUMP) begin
            state_d = S_LOAD_JUMP_1;
          end else if (op == OP_LOAD) begin
            if (src == SOURCE_REGISTER) state_d = S_COPY_REGISTER_1;
            else if (src == SOURCE_IMMEDIATE) state_d = S_FETCH_IMMEDIATE;
            else if (src == SOURCE_MEMORY) state_d = S_FETCH_ADDRESS_1;
            else begin
              state_d  = S_HALT;
              setFault = 1'b1;
            end
          end else if ((op == OP_STORE) || (op == OP_MOVE)) begin
            state_d = S_FETCH_ADDRESS_1;
          end else if (isAlu) begin
            if (src == SOURCE_REGISTER) state_d = S_ALU_OPERATION;
            else if (src == SOURCE_IMMEDIATE) state_d = S_FETCH_IMMEDIATE;
            else begin
              state_d  = S_HALT;
              setFault = 1'b1;
            end
          end else begin
            state_d = S_HALT;
          end
        end
        S_LOAD_JUMP_1:     state_d = S_LOAD_JUMP_2;
        S_LOAD_JUMP_2:     state_d = S_EXECUTE_JUMP;
        S_EXECUTE_JUMP:    state_d = S_FETCH_1;
        S_COPY_REGISTER_1: state_d = S_COPY_REGISTER_2;
        S_COPY_REGISTER_2: state_d = S_FETCH_1;
        S_FETCH_IMMEDIATE: state_d = (op == OP_LOAD) ? S_FETCH_1 : S_ALU_OPERATION;
        S_FETCH_ADDRESS_1: state_d = S_FETCH_ADDRESS_2;
        S_FETCH_ADDRESS_2: begin
          if (op == OP_LOAD) state_d = S_FETCH_MEMORY;
          else if (op == OP_STORE) state_d = S_STORE_MEMORY;
          else if (op == OP_MOVE) state_d = S_TEMP_FETCH;
          else begin
            state_d  = S_HALT;
            setFault = 1'b1;
          end
        end
        S_FETCH_MEMORY:    state_d = S_FETCH_1;
        S_STORE_MEMORY:    state_d = S_FETCH_1;
        S_TEMP_FETCH:      state_d = S_FETCH_ADDRESS_3;
        S_FETCH_ADDRESS_3: state_d = S_FETCH_ADDRESS_4;
        S_FETCH_ADDRESS_4: state_d = S_TEMP_STORE;
        S_TEMP_STORE:      state_d = S_FETCH_1;
        S_ALU_OPERATION:   state_d = S_STORE_RESULT_1;
        S_STORE_RESULT_1:
          state_d = ((op == OP_MULTIPLY) && (RESULT_BEATS > 1)) ? S_STORE_RESULT_2 : S_FETCH_1;
        S_STORE_RESULT_2:  state_d = (beat_q == LAST_BEAT) ? S_FETCH_1 : S_STORE_RESULT_2;
        S_HALT:            state_d = (!fault_q && resume) ? S_FETCH_1 : S_HALT;
        default: begin
          state_d  = S_HALT;
          setFault = 1'b1;
        end
      endcase
    end
  end

  // Retirement is any return to fetch that did not come from reset or a halt resume.
  always_comb begin
    fault_d = fault_q | setFault;
    done_d  = (state_d == S_FETCH_1) && (state_q != S_RESET) && (state_q != S_HALT);
    beat_d  = (state_d == S_STORE_RESULT_2) ? beat_q + 2'd1 : 2'd0;
    wait_d  = wait_q;
    if (state_d != state_q) wait_d = '0;
    else if (stall && (wait_q != WAIT_MAX)) wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RESET;
      fault_q <= 1'b0;
      done_q  <= 1'b0;
      beat_q  <= 2'd0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      done_q  <= done_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
    end
  end

  assign state      = state_q;
  assign halted     = (state_q == S_HALT);
  assign fault      = fault_q;
  assign instr_done = done_q;
  assign beat       = beat_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-instruction state paths from an instruction-level
// model are queued cycle by cycle and compared by an independent negedge monitor.
module tb_control_sequencer;

  localparam int IW = 16;
  localparam int RB = 3;
  localparam int WL = 4;

  localparam logic [4:0] S_RESET = 5'd0,  S_F1 = 5'd1,  S_F2 = 5'd2,  S_FI = 5'd3;
  localparam logic [4:0] S_FA1   = 5'd4,  S_FA2 = 5'd5, S_FA3 = 5'd6, S_FA4 = 5'd7;
  localparam logic [4:0] S_LJ1   = 5'd8,  S_LJ2 = 5'd9, S_EJ = 5'd10, S_CR1 = 5'd11;
  localparam logic [4:0] S_CR2   = 5'd12, S_FM = 5'd13, S_SM = 5'd14, S_TF = 5'd15;
  localparam logic [4:0] S_TS    = 5'd16, S_ALU = 5'd17, S_SR1 = 5'd18, S_SR2 = 5'd19;
  localparam logic [4:0] S_HALT  = 5'd20, NONE = 5'd31;

  localparam logic [4:0] OP_NOP = 5'b00000, OP_MUL = 5'b00101, OP_LOAD = 5'b10000;
  localparam logic [4:0] OP_STORE = 5'b10001, OP_MOVE = 5'b10010, OP_JUMP = 5'b10011;
  localparam logic [1:0] SRC_REG = 2'b00, SRC_IMM = 2'b01, SRC_MEM = 2'b10;

  logic          clock = 1'b0;
  logic          reset;
  logic [IW-1:0] instruction;
  logic          mem_ready;
  logic          resume;
  logic [4:0]    state;
  logic          halted;
  logic          fault;
  logic          instr_done;
  logic [1:0]    beat;

  always #5 clock = ~clock;

  control_sequencer #(.INSTR_WIDTH(IW), .RESULT_BEATS(RB), .WAIT_LIMIT(WL)) dut (
    .clock(clock), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
    .resume(resume), .state(state), .halted(halted), .fault(fault),
    .instr_done(instr_done), .beat(beat)
  );

  typedef struct packed {
    logic [4:0] st;
    logic       flt;
    logic       dn;
    logic       bc;
    logic [1:0] bt;
  } exp_t;

  exp_t       expQ[$];
  exp_t       monE;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         expFault = 1'b0;
  bit         pendingDone = 1'b0;
  bit         inHalt = 1'b0;
  logic [4:0] pathQ[$];
  bit         pathHalt;
  bit         pathFault;

  logic [4:0] opList [12] = '{OP_NOP, OP_MUL, OP_LOAD, OP_STORE, OP_MOVE, OP_JUMP,
                              5'b00001, 5'b01000, 5'b01101, 5'b01110, 5'b10111, 5'b11111};

  task automatic checkOutput(input string name, input logic [4:0] got, input logic [4:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  // Monitor: one queued expectation per cycle, compared mid-cycle.
  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      checkOutput("state", state, monE.st);
      checkOutput("fault", {4'b0, fault}, {4'b0, monE.flt});
      checkOutput("halted", {4'b0, halted}, {4'b0, (monE.st == S_HALT)});
      checkOutput("instr_done", {4'b0, instr_done}, {4'b0, monE.dn});
      if (monE.bc) checkOutput("beat", {3'b0, beat}, {3'b0, monE.bt});
      cyc++;
    end
  end

  task automatic applyStimulus(input bit rst, input bit rdy, input bit res, input logic [4:0] st,
                               input bit bc, input logic [1:0] bt, input bit dn);
    exp_t e;
    e.st = st; e.flt = expFault; e.dn = dn; e.bc = bc; e.bt = bt;
    expQ.push_back(e);
    reset = rst; mem_ready = rdy; resume = res;
    @(posedge clock);
    #1;
  endtask

  function automatic bit isMem(input logic [4:0] s);
    return s inside {S_F2, S_FI, S_FA2, S_FA4, S_LJ2, S_FM, S_SM, S_TF, S_TS};
  endfunction

  // Instruction-level reference: the full list of states an instruction walks through.
  task automatic buildPath(input logic [4:0] op, input logic [1:0] src);
    pathQ.delete();
    pathQ.push_back(S_F1);
    pathQ.push_back(S_F2);
    pathHalt = 1'b0;
    pathFault = 1'b0;
    if (op == OP_NOP) begin
    end else if (op == OP_JUMP) begin
      pathQ.push_back(S_LJ1); pathQ.push_back(S_LJ2); pathQ.push_back(S_EJ);
    end else if (op == OP_LOAD) begin
      if (src == SRC_REG) begin pathQ.push_back(S_CR1); pathQ.push_back(S_CR2); end
      else if (src == SRC_IMM) pathQ.push_back(S_FI);
      else if (src == SRC_MEM) begin
        pathQ.push_back(S_FA1); pathQ.push_back(S_FA2); pathQ.push_back(S_FM);
      end else begin pathHalt = 1'b1; pathFault = 1'b1; end
    end else if (op == OP_STORE) begin
      pathQ.push_back(S_FA1); pathQ.push_back(S_FA2); pathQ.push_back(S_SM);
    end else if (op == OP_MOVE) begin
      pathQ.push_back(S_FA1); pathQ.push_back(S_FA2); pathQ.push_back(S_TF);
      pathQ.push_back(S_FA3); pathQ.push_back(S_FA4); pathQ.push_back(S_TS);
    end else if (op[4] == 1'b0 && op != 5'b01101 && op != 5'b01110) begin
      if (src == SRC_REG || src == SRC_IMM) begin
        if (src == SRC_IMM) pathQ.push_back(S_FI);
        pathQ.push_back(S_ALU);
        pathQ.push_back(S_SR1);
        if (op == OP_MUL) for (int k = 1; k < RB; k++) pathQ.push_back(S_SR2);
      end else begin pathHalt = 1'b1; pathFault = 1'b1; end
    end else begin
      pathHalt = 1'b1;
    end
  endtask

  task automatic applyReset(input logic [4:0] cur, input bit bc, input logic [1:0] bt, input bit dn);
    applyStimulus(1'b1, 1'($urandom), 1'($urandom), cur, bc, bt, dn);
    expFault = 1'b0;
    applyStimulus(1'b0, 1'($urandom), 1'($urandom), S_RESET, 1'b1, 2'd0, 1'b0);
    pendingDone = 1'b0;
    inHalt = 1'b0;
  endtask

  task automatic runInstr(input logic [4:0] op, input logic [1:0] src, input int maxWaits,
                          input logic [4:0] forceSt, input int forceN, input logic [4:0] resetSt);
    logic [8:0] filler;
    int         sr2;
    filler = 9'($urandom);
    instruction = {op, src, filler};
    buildPath(op, src);
    sr2 = 0;
    for (int i = 0; i < pathQ.size(); i++) begin
      logic [4:0] s;
      bit         bc;
      logic [1:0] bt;
      bit         dn;
      int         n;
      s = pathQ[i]; bc = 1'b0; bt = 2'd0;
      dn = (i == 0) && pendingDone;
      if (s == S_SR1) bc = 1'b1;
      else if (s == S_SR2) begin sr2++; bc = 1'b1; bt = 2'(sr2); end
      if (s == resetSt) begin
        applyReset(s, bc, bt, dn);
        return;
      end
      if (isMem(s)) begin
        n = (s == forceSt) ? forceN : int'($urandom_range(0, maxWaits));
        if (n > WL) begin
          for (int k = 0; k <= WL; k++) applyStimulus(1'b0, 1'b0, 1'($urandom), s, bc, bt, dn);
          expFault = 1'b1; inHalt = 1'b1; pendingDone = 1'b0;
          return;
        end
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'($urandom), s, bc, bt, dn);
        applyStimulus(1'b0, 1'b1, 1'($urandom), s, bc, bt, dn);
      end else begin
        applyStimulus(1'b0, 1'($urandom), 1'($urandom), s, bc, bt, dn);
      end
    end
    if (pathHalt) begin
      if (pathFault) expFault = 1'b1;
      inHalt = 1'b1;
      pendingDone = 1'b0;
    end else begin
      pendingDone = 1'b1;
    end
  endtask

  // Faulted halts ignore resume and need a reset; clean halts leave on a resume pulse.
  task automatic handleHalt();
    if (expFault) begin
      repeat (2 + $urandom_range(0, 1)) applyStimulus(1'b0, 1'($urandom), 1'b1, S_HALT, 1'b0, 2'd0, 1'b0);
      applyReset(S_HALT, 1'b0, 2'd0, 1'b0);
    end else begin
      repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'($urandom), 1'b0, S_HALT, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b0, 1'($urandom), 1'b1, S_HALT, 1'b0, 2'd0, 1'b0);
      inHalt = 1'b0;
      pendingDone = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; resume = 1'b0; instruction = '0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, S_RESET, 1'b1, 2'd0, 1'b0);

    runInstr(OP_MUL, SRC_REG, 0, NONE, 0, NONE);
    runInstr(OP_NOP, SRC_REG, 0, NONE, 0, NONE);
    runInstr(OP_LOAD, SRC_MEM, 0, S_FM, 2, NONE);
    runInstr(OP_STORE, SRC_REG, 0, S_FA2, 99, NONE);
    handleHalt();
    runInstr(OP_LOAD, 2'b11, 0, NONE, 0, NONE);
    handleHalt();
    runInstr(5'b11111, SRC_REG, 0, NONE, 0, NONE);
    handleHalt();
    repeat (4) runInstr(OP_NOP, SRC_REG, 0, NONE, 0, NONE);
    runInstr(OP_MOVE, SRC_REG, 0, NONE, 0, S_TF);
    runInstr(OP_NOP, SRC_REG, 0, NONE, 0, NONE);

    for (int i = 0; i < 80; i++) begin
      logic [4:0] op;
      logic [1:0] src;
      op = opList[$urandom_range(0, 11)];
      src = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) runInstr(op, src, 2, S_F2, 99, NONE);
      else runInstr(op, src, 2, NONE, 0, NONE);
      if (inHalt) handleHalt();
    end

    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clock);
    #1;
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain got=%0d want=0 pending expectations", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised control sequencer for the 8-bit, 5-stage core. It decodes the instruction-register contents and produces the current `S_*` state that drives the datapath, register file, ALU and memory interface. It adds three things: memory wait-states through a ready handshake, a configurable multiply result-write length, and fault detection with a bounded wait timeout and halt/resume control. State and opcode encodings are the `constants.sv` macros.

## Interface
Parameters:
- `INSTR_WIDTH`, default 16: instruction width, minimum 16. The opcode is `instruction[INSTR_WIDTH-1 -: 5]`. The source field is the next 2 bits below the opcode.
- `RESULT_BEATS`, default 2: number of result-write cycles for `MULTIPLY`, range 1..4.
- `WAIT_LIMIT`, default 15: number of consecutive not-ready cycles tolerated in a memory state. 0 disables the timeout.

Ports:
- `clock`, input, 1: the single clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `instruction`, input, `INSTR_WIDTH`: contents of the instruction register.
- `mem_ready`, input, 1: memory has completed the access of the current state.
- `resume`, input, 1: request to leave a non-fault halt.
- `state`, output, 5: current state (`S_*`).
- `halted`, output, 1: high when `state == S_HALT`.
- `fault`, output, 1: sticky error flag.
- `instr_done`, output, 1: one-cycle pulse when an instruction retires.
- `beat`, output, 2: index of the current result-write beat.

## Operation
- Reset: while `reset` is 1 at a clock edge, the block sets `state = S_RESET` and clears `fault`, `instr_done`, `beat` and the wait counter. `halted` is 0. This applies mid-instruction and in any state.
- `S_RESET` goes to `S_FETCH_1` on the first edge with `reset` = 0.
- Memory states: `S_FETCH_2`, `S_FETCH_IMMEDIATE`, `S_FETCH_ADDRESS_2`, `S_FETCH_ADDRESS_4`, `S_LOAD_JUMP_2`, `S_FETCH_MEMORY`, `S_STORE_MEMORY`, `S_TEMP_FETCH`, `S_TEMP_STORE`.
  - The state advances only on an edge where `mem_ready` = 1. Otherwise it holds and the wait counter increments.
  - The wait counter clears on every state change.
  - If `WAIT_LIMIT` > 0 and the counter reaches `WAIT_LIMIT` while `mem_ready` = 0, the next state is `S_HALT` with `fault` = 1.
- All other states advance unconditionally. `mem_ready` is ignored there.
- Decode in `S_FETCH_2` (when ready), on opcode `op` and source field `src`:
  - `NOP` goes to `S_FETCH_1`.
  - `JUMP` goes to `S_LOAD_JUMP_1`.
  - `LOAD`: `SOURCE_REGISTER` goes to `S_COPY_REGISTER_1`, `SOURCE_IMMEDIATE` to `S_FETCH_IMMEDIATE`, `SOURCE_MEMORY` to `S_FETCH_ADDRESS_1`. Any other `src` goes to `S_HALT` with `fault` = 1.
  - `STORE` and `MOVE` go to `S_FETCH_ADDRESS_1`.
  - ALU class (`op[4]` = 0, `op` not 01101/01110, and not one of the opcodes above): `SOURCE_REGISTER` goes to `S_ALU_OPERATION`, `SOURCE_IMMEDIATE` to `S_FETCH_IMMEDIATE`. Any other `src` goes to `S_HALT` with `fault` = 1.
  - Any other opcode goes to `S_HALT` with `fault` = 0.
- Fixed transitions:
  - `S_LOAD_JUMP_1` → `_2` → `S_EXECUTE_JUMP` → `S_FETCH_1`.
  - `S_COPY_REGISTER_1` → `_2` → `S_FETCH_1`.
  - `S_FETCH_IMMEDIATE` goes to `S_FETCH_1` for `LOAD`, otherwise to `S_ALU_OPERATION`.
  - `S_FETCH_ADDRESS_1` → `_2`.
  - From `S_FETCH_ADDRESS_2`: `LOAD` goes to `S_FETCH_MEMORY`, `STORE` to `S_STORE_MEMORY`, `MOVE` to `S_TEMP_FETCH`. Any other opcode goes to `S_HALT` with `fault` = 1.
  - `S_FETCH_MEMORY` and `S_STORE_MEMORY` go to `S_FETCH_1`.
  - `S_TEMP_FETCH` → `S_FETCH_ADDRESS_3` → `_4` → `S_TEMP_STORE` → `S_FETCH_1`.
  - `S_ALU_OPERATION` → `S_STORE_RESULT_1`.
- Result write:
  - `S_STORE_RESULT_1` sets `beat` = 0. It goes to `S_STORE_RESULT_2` when `op == MULTIPLY` and `RESULT_BEATS` > 1; otherwise it goes to `S_FETCH_1`.
  - `S_STORE_RESULT_2` increments `beat` each cycle. It leaves to `S_FETCH_1` when `beat == RESULT_BEATS-1`.
- Halt:
  - `S_HALT` with `fault` = 0 and `resume` = 1 goes to `S_FETCH_1`. Otherwise it holds.
  - `fault` clears only on reset.
- `instr_done` is registered. It is 1 exactly in the first cycle of `S_FETCH_1` entered from an execution state. It is 0 when `S_FETCH_1` is entered from `S_RESET` or from a halt resume.

## Timing
- One state per cycle unless a memory wait-state stretches it.
- Cycles per instruction with `mem_ready` held at 1, counted from `S_FETCH_1` to the next `S_FETCH_1`:

| Instruction | Cycles |
|---|---|
| `NOP` | 2 |
| `LOAD` immediate | 3 |
| `LOAD` register | 4 |
| ALU register | 4 |
| ALU immediate | 5 |
| `LOAD` memory | 5 |
| `STORE` | 5 |
| `JUMP` | 5 |
| `MOVE` | 8 |
| `MULTIPLY` | 3 + `RESULT_BEATS` |

- Each not-ready cycle in a memory state adds 1 cycle.
- Timeout: with `mem_ready` stuck at 0, the block is in `S_HALT` exactly `WAIT_LIMIT`+1 cycles after entering the memory state.
- `instruction` is sampled every cycle. It must be stable from `S_FETCH_2` until retirement.
- Reset has priority over `resume`, `mem_ready` and every transition.

## Test plan
- Reset in the middle of `MOVE` at `S_TEMP_FETCH` → next state is `S_RESET` with `fault`/`instr_done`/`beat` = 0. One cycle after release → `S_FETCH_1`, with `instr_done` = 0.
- `MULTIPLY` register, `RESULT_BEATS` = 3, `mem_ready` = 1 → state sequence `F1, F2, ALU, SR1, SR2, SR2, F1`. `beat` reads 0, 1, 2, and `instr_done` pulses once.
- `LOAD` memory with `mem_ready` low for 2 cycles in `S_FETCH_MEMORY` → 7-cycle instruction, and `S_FETCH_MEMORY` is held for 3 cycles.
- `STORE`, `WAIT_LIMIT` = 4, `mem_ready` stuck at 0 in `S_FETCH_ADDRESS_2` → `S_HALT` after 5 cycles with `fault` = 1. `resume` is then ignored, and only reset recovers.
- `LOAD` with `src` = 2'b11 → `S_HALT` with `fault` = 1 the cycle after `S_FETCH_2`.
- Opcode 5'b11111 → `S_HALT` with `fault` = 0. Pulse `resume` → `S_FETCH_1` the next cycle with `instr_done` = 0. Back-to-back `NOP`s then show `instr_done` every 2 cycles.
